// File: rtl/jtkcpu_pkg.sv
// Shared constants for the KONAMI-1 bus controller:
// address-source codes, reset/interrupt vectors and FSM encoding.
package jtkcpu_pkg;

  localparam logic [2:0] SEL_PCOP  = 3'd0;
  localparam logic [2:0] SEL_PCOPD = 3'd1;
  localparam logic [2:0] SEL_IDX   = 3'd2;
  localparam logic [2:0] SEL_PSH   = 3'd3;
  localparam logic [2:0] SEL_X     = 3'd4;
  localparam logic [2:0] SEL_Y     = 3'd5;
  localparam logic [2:0] SEL_DIR   = 3'd6;

  localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
  localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
  localparam logic [15:0] VEC_NMI  = 16'hFFFC;
  localparam logic [15:0] VEC_RST  = 16'hFFFE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // bytes-1 limited to what the data bus can hold
  function automatic logic [1:0] clamp_len(
    input logic [1:0] len,
    input int         maxb
  );
    if (int'(len) >= maxb) return 2'(maxb - 1);
    return len;
  endfunction

endpackage

// File: rtl/jtkcpu_busctrl_addrmux.sv
// Base address selection: a pending interrupt vector
// takes priority over the requested address source.
module jtkcpu_busctrl_addrmux
  import jtkcpu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [3:0]  intvec,
  input  logic [15:0] pc,
  input  logic [15:0] idx_addr,
  input  logic [15:0] psh_addr,
  input  logic [15:0] regs_x,
  input  logic [15:0] regs_y,
  input  logic [7:0]  dp,
  output logic [15:0] base,
  output logic        vec
);

  logic [15:0] src;

  always_comb begin
    src = pc;
    unique case (sel)
      SEL_PCOP:  src = pc;
      SEL_PCOPD: src = pc;
      SEL_IDX:   src = idx_addr;
      SEL_PSH:   src = psh_addr;
      SEL_X:     src = regs_x;
      SEL_Y:     src = regs_y;
      SEL_DIR:   src = {dp, idx_addr[7:0]};
      default:   src = pc;
    endcase
  end

  // highest set request bit wins
  always_comb begin
    base = src;
    vec  = |intvec;
    priority case (1'b1)
      intvec[3]: base = VEC_RST;
      intvec[2]: base = VEC_NMI;
      intvec[1]: base = VEC_FIRQ;
      intvec[0]: base = VEC_IRQ;
      default:   base = src;
    endcase
  end

endmodule

// File: rtl/jtkcpu_busctrl.sv
// Multi-byte big-endian bus controller with wait states,
// bus_ok stall, hold freeze and vector fetches.
module jtkcpu_busctrl
  import jtkcpu_pkg::*;
#(
  parameter int MAXB = 2,
  parameter int WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              hold,
  input  logic              req,
  input  logic [2:0]        sel,
  input  logic [1:0]        len,
  input  logic              wr,
  input  logic [8*MAXB-1:0] wdata,
  input  logic [15:0]       pc,
  input  logic [15:0]       idx_addr,
  input  logic [15:0]       psh_addr,
  input  logic [15:0]       regs_x,
  input  logic [15:0]       regs_y,
  input  logic [7:0]        dp,
  input  logic [3:0]        intvec,
  input  logic [7:0]        din,
  input  logic              bus_ok,
  output logic [15:0]       addr,
  output logic [7:0]        dout,
  output logic              we,
  output logic [8*MAXB-1:0] rdata,
  output logic [7:0]        op,
  output logic              busy,
  output logic              ack,
  output logic              is_op,
  output logic              up_pc
);

  localparam int         DW    = 8 * MAXB;
  localparam logic [3:0] WAITC = 4'(WAIT);
  localparam logic [1:0] VLEN  = clamp_len(2'd1, MAXB);

  state_t         st, st_nx;
  logic [1:0]     k, last;
  logic [3:0]     wc;
  logic           wr_r, vec_r, opf_r, op_arm;
  logic [DW-1:0]  wbuf;
  logic [DW+7:0]  sh;
  logic [15:0]    base;
  logic           vec;
  logic           step, start, done, fin, op_hit;
  logic [1:0]     nlen;

  function automatic logic [7:0] byte_of(
    input logic [DW-1:0] d,
    input logic [1:0]    i
  );
    logic [DW-1:0] s;
    s = d >> {i, 3'b000};
    return s[7:0];
  endfunction

  jtkcpu_busctrl_addrmux u_mux (
    .sel      (sel),
    .intvec   (intvec),
    .pc       (pc),
    .idx_addr (idx_addr),
    .psh_addr (psh_addr),
    .regs_x   (regs_x),
    .regs_y   (regs_y),
    .dp       (dp),
    .base     (base),
    .vec      (vec)
  );

  always_comb begin
    step   = cen & ~hold;
    start  = (st == ST_IDLE) & (vec | req);
    nlen   = vec ? VLEN : clamp_len(len, MAXB);
    done   = (st == ST_XFER) & (wc == WAITC) & bus_ok;
    fin    = done & (k == last);
    op_hit = done & opf_r & ~wr_r & (k == 2'd0);
    sh     = {rdata, din};
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (step) begin
      unique case (st)
        ST_IDLE: if (start) st_nx = ST_XFER;
        ST_XFER: if (fin)   st_nx = ST_IDLE;
        default: st_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      dout   <= '0;
      we     <= 1'b0;
      rdata  <= '0;
      op     <= '0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      is_op  <= 1'b0;
      up_pc  <= 1'b0;
      k      <= '0;
      wc     <= '0;
      last   <= '0;
      wr_r   <= 1'b0;
      vec_r  <= 1'b0;
      opf_r  <= 1'b0;
      op_arm <= 1'b0;
      wbuf   <= '0;
    end else if (!hold) begin
      ack   <= 1'b0;
      is_op <= 1'b0;
      up_pc <= 1'b0;
      if (cen && start) begin
        addr   <= base;
        rdata  <= '0;
        busy   <= 1'b1;
        k      <= '0;
        wc     <= '0;
        last   <= nlen;
        vec_r  <= vec;
        wr_r   <= ~vec & wr;
        opf_r  <= ~vec & (sel == SEL_PCOP);
        op_arm <= 1'b0;
        wbuf   <= wdata;
        if (!vec && wr) begin
          dout <= byte_of(wdata, nlen);
          we   <= 1'b1;
        end
      end else if (cen && st == ST_XFER) begin
        if (!done) begin
          if (wc != WAITC) wc <= wc + 4'd1;
        end else begin
          if (!wr_r) rdata <= sh[DW-1:0];
          if (op_hit) begin
            op     <= din;
            op_arm <= 1'b1;
          end
          if (!fin) begin
            k    <= k + 2'd1;
            wc   <= '0;
            addr <= addr + 16'd1;
            if (wr_r) dout <= byte_of(wbuf, last - k - 2'd1);
          end else begin
            we    <= 1'b0;
            busy  <= 1'b0;
            ack   <= 1'b1;
            is_op <= op_arm | op_hit;
            up_pc <= vec_r;
          end
        end
      end
    end
  end

endmodule

// File: doc/jtkcpu_busctrl.md
Name: jtkcpu_busctrl

Overview:
Parametrised bus/memory controller for the KONAMI-1 style CPU core. It sits between the control unit and the external 8-bit memory bus. It performs transfers of 1..MAXB bytes, big-endian, from a selectable address source. It adds programmable wait states plus a bus_ok stall, and runs interrupt/reset vector fetches through an explicit req/ack handshake.

Parameters:
MAXB, 2, maximum bytes per transfer (1..4); sets the rdata/wdata width to 8*MAXB.
WAIT, 0, extra cen cycles inserted per byte (0..15).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cen  in  1  clock enable; all state advances only on cen=1 edges
hold  in  1  freeze: no state/output change while high
req  in  1  start transfer (sampled in IDLE only)
sel  in  3  address source: 0 PC opcode, 1 PC operand, 2 idx_addr, 3 psh_addr, 4 regs_x, 5 regs_y, 6 direct {dp,idx_addr[7:0]}, 7 = same as 1
len  in  2  bytes-1; values >= MAXB clamp to MAXB-1
wr  in  1  1 = write transfer
wdata  in  8*MAXB  write data, right-aligned
pc, idx_addr, psh_addr, regs_x, regs_y  in  16 each  address sources
dp  in  8  direct page
intvec  in  4  one-hot interrupt request: bit0 IRQ, 1 FIRQ, 2 NMI, 3 RST
din  in  8  bus read data
bus_ok  in  1  external ready; low stalls the current byte
addr  out  16  bus address
dout  out  8  bus write data
we  out  1  write strobe
rdata  out  8*MAXB  read data, right-aligned
op  out  8  last opcode fetched
busy  out  1  transfer in progress
ack  out  1  one-clk pulse: transfer complete
is_op  out  1  one-clk pulse with ack when op was updated
up_pc  out  1  one-clk pulse with ack at the end of a vector fetch

Behaviour:
- Reset (sync): state IDLE; addr=0, dout=0, we=0, rdata=0, op=0, busy=0, ack=0, is_op=0, up_pc=0. Reset mid-transfer aborts it; we=0 after that edge.
- hold=1 overrides cen: all registers keep their values, including we.
- States: IDLE, XFER. Counters: byte index k (2b), wait count wc (4b).
- IDLE, cen edge, intvec!=0:
  - Vector fetch, with priority over req. Highest set bit wins: RST > NMI > FIRQ > IRQ.
  - addr <= vector (IRQ FFF8, FIRQ FFF6, NMI FFFC, RST FFFE); n=2 bytes (clamped by MAXB); read.
  - busy<=1, rdata<=0, go to XFER.
- IDLE, cen edge, req=1:
  - Latch base address from sel, n=len+1 (clamped), wr, wdata.
  - addr<=base, rdata<=0, busy<=1, k=0, wc=0; go to XFER.
  - If wr: dout<=wdata byte n-1 (MSB first), we<=1.
- XFER, cen edge:
  - Byte completes when wc==WAIT and bus_ok=1; otherwise wc increments (saturating at WAIT) and addr/dout/we hold.
  - On completion, read transfers: rdata <= {rdata[8*MAXB-9:0], din}. If sel==0 and k==0, op<=din and the is_op pulse is armed.
  - If k<n-1: k++, wc=0, addr<=addr+1 (16-bit wrap, FFFF->0000). For writes, dout<=next lower byte and we stays 1.
  - If k==n-1: we<=0, busy<=0, ack<=1 (plus is_op/up_pc as applicable); go to IDLE.
- Pulses ack/is_op/up_pc clear on the next clk edge regardless of cen.
- Latency with WAIT=0 and bus_ok=1: accept at edge N; byte k sampled at cen edge N+1+k; ack visible after cen edge N+n. Each additional wait/stall cycle adds 1.
- req is ignored while busy. req is not queued: the control unit keeps req high until ack.
- intvec changes during XFER are ignored; they are resampled in IDLE.
- 1-byte read: rdata = {0…,b0}. 1-byte write drives only wdata[7:0].

Decomposition:
- Package jtkcpu_pkg holds:
  - sel codes (SEL_PCOP, SEL_PCOPD, SEL_IDX, SEL_PSH, SEL_X, SEL_Y, SEL_DIR)
  - vector constants VEC_IRQ/FIRQ/NMI/RST
  - state encoding
- One sub-module, jtkcpu_busctrl_addrmux: combinational selection of the base address from sel/intvec.

Test Plan:
- MAXB=2, WAIT=0: req sel=0 len=0 pc=1234, mem[1234]=86 -> addr=1234 one cen after req; ack+is_op after next cen edge; op=86, rdata=0086.
- MAXB=2: req sel=4 len=1 regs_x=FFFF, mem[FFFF]=12, mem[0000]=34 -> addr FFFF then 0000; rdata=1234; ack once.
- MAXB=4, WAIT=2: write len=3 sel=2 idx_addr=2000 wdata=A1B2C3D4 -> bytes A1,B2,C3,D4 at 2000..2003; each byte held 3 cen cycles; we high throughout; ack after 12 cen edges.
- intvec=1010 with req=1 -> RST wins; addr FFFE/FFFF read; rdata=vector; ack+up_pc pulse; req served afterwards.
- bus_ok low 5 cycles mid-byte, and hold high for 3 cycles -> addr/dout/we frozen; completion delayed exactly 5 (+3 hold) cycles.
- rst asserted during write byte 1 -> next edge: we=0, busy=0, IDLE; a new req then behaves normally.
